sensor_conditioner: RTL and testbench
=====================================

Name: sensor_conditioner

Overview:
Front-end conditioning stage that sits directly upstream of the smart-home controller FSM. It synchronises and debounces the raw door, window and fire-alarm contacts, and averages the 7-bit temperature samples. It drives the controller's SFD, SRD, SW, SFA and ST inputs, and flags stale or out-of-range temperature data. Single clock domain, except that the raw contacts are asynchronous.

Parameters:
DEB_CYCLES, 8, consecutive stable cycles required before SFD/SRD/SW change (>=2)
FA_DEB, 2, consecutive stable cycles required before SFA changes (>=1)
FA_HOLD, 16, minimum cycles SFA stays high once asserted
MAX_TEMP, 120, largest accepted temp_in value; larger samples are discarded
STALE_CYCLES, 1024, cycles without an accepted sample before temp_stale asserts
RST_TEMP, 60, value ST takes in reset (neutral: neither heat nor cool)

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  reset, synchronous, active-low (0 = reset)
raw_fd  in  1  front-door contact, asynchronous
raw_rd  in  1  rear-door contact, asynchronous
raw_w  in  1  window contact, asynchronous
raw_fa  in  1  fire-alarm contact, asynchronous
temp_in  in  7  temperature sample, synchronous to Clk, unsigned
temp_valid  in  1  one-cycle strobe: temp_in is valid this cycle
SFD  out  1  debounced front door
SRD  out  1  debounced rear door
SW  out  1  debounced window
SFA  out  1  debounced, hold-extended fire alarm
ST  out  7  averaged temperature
temp_stale  out  1  no accepted sample within STALE_CYCLES
temp_err  out  1  one-cycle pulse when a sample is rejected

Behaviour:
- Reset (Rst=0 at a rising edge):
  - SFD=SRD=SW=SFA=0, ST=RST_TEMP, temp_stale=0, temp_err=0.
  - Synchroniser flops, debounce counters, hold counter, accumulator, sample count and stale counter all cleared.
  - Reset asserted mid-operation discards any partial average and any pending debounce.
- Synchroniser: each raw_* input passes through 2 flops to give s_*. Only s_* is used downstream.
- Debounce (SFD/SRD/SW), per channel with an independent counter:
  - If s equals the output, the counter is cleared.
  - Otherwise the counter increments.
  - On the edge where the counter would reach DEB_CYCLES, the output takes s and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles restarts the count and never reaches the output.
  - Latency from a stable raw change to the output change is exactly DEB_CYCLES+2 clocks.
- Fire alarm:
  - Debounced with the same rule using FA_DEB.
  - When SFA rises, a hold counter loads FA_HOLD.
  - While the hold counter is nonzero, SFA stays 1, the counter decrements, and the fall debounce is held cleared.
  - After the hold expires, SFA falls only after s_fa has been 0 for FA_DEB consecutive cycles.
  - If s_fa is high again during the hold, the hold is not reloaded.
- Temperature averaging:
  - A sample is accepted when temp_valid=1 and temp_in<=MAX_TEMP.
  - If temp_valid=1 and temp_in>MAX_TEMP, the sample is dropped, temp_err pulses high the next cycle, and the accumulator and sample count are unchanged.
  - Accepted samples add into a 9-bit accumulator; a 2-bit sample count increments per accepted sample.
  - On the 4th accepted sample: ST <= (acc + temp_in)>>2, truncated. The accumulator and count clear in the same edge. ST updates 1 clock after that strobe.
  - ST holds its value between updates. The result is never above MAX_TEMP, so there is no overflow.
- Staleness:
  - The stale counter clears on every accepted sample and otherwise increments, saturating.
  - temp_stale=1 when the counter reaches STALE_CYCLES.
  - temp_stale clears on the edge of the next accepted sample.
  - ST is frozen while stale; rejected samples do not clear staleness.
- Simultaneous events: all channels are independent. An accepted 4th sample and a stale clear in the same cycle both take effect.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Rst low for 3 clocks, then high → SFD/SRD/SW/SFA=0, ST=60, temp_stale=0.
2. raw_fd 0→1 held → SFD=1 exactly 10 clocks later. A 7-cycle pulse on raw_w → SW stays 0.
3. raw_fa 3-cycle pulse → SFA rises 4 clocks after the raw edge and stays high 16 cycles. It then falls 2 clocks after hold expiry, since raw is already low.
4. temp_valid with temp_in = 70, 71, 72, 74 → ST=71 one clock after the 4th strobe. Then 121 → temp_err pulse, and the count is unchanged.
5. No temp_valid for 1024 cycles → temp_stale=1 with ST held. One sample of 50 → temp_stale=0, and ST stays unchanged until 3 more samples arrive.
6. Rst=0 after 2 of 4 samples and a half-count debounce on raw_rd → after reset, ST=60 and SRD=0. Four fresh samples of 40 → ST=40.

Source files
------------

// File: rtl/sensor_conditioner.sv
// Sensor front-end for the smart-home controller.
// Synchronises and debounces the door, window and fire-alarm contacts,
// stretches the fire alarm by a minimum hold time, and averages the
// temperature samples in blocks of four. It also flags stale input and
// rejected temperature samples. Every output comes straight from a flop.
module sensor_conditioner #(
    parameter int DEB_CYCLES   = 8,
    parameter int FA_DEB       = 2,
    parameter int FA_HOLD      = 16,
    parameter int MAX_TEMP     = 120,
    parameter int STALE_CYCLES = 1024,
    parameter int RST_TEMP     = 60
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       raw_fd,
    input  logic       raw_rd,
    input  logic       raw_w,
    input  logic       raw_fa,
    input  logic [6:0] temp_in,
    input  logic       temp_valid,
    output logic       SFD,
    output logic       SRD,
    output logic       SW,
    output logic       SFA,
    output logic [6:0] ST,
    output logic       temp_stale,
    output logic       temp_err
);

    // Each counter only needs to hold "target - 1": reaching the target is
    // the flip event itself, and the counter clears on that edge.
    localparam int DW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int FW  = (FA_DEB > 1) ? $clog2(FA_DEB) : 1;
    localparam int HW  = $clog2(FA_HOLD + 1);
    localparam int SCW = $clog2(STALE_CYCLES + 1);

    localparam logic [6:0]     MAX_T   = 7'(MAX_TEMP);
    localparam logic [6:0]     RST_T   = 7'(RST_TEMP);
    localparam logic [DW-1:0]  DEB_TOP = DW'(DEB_CYCLES - 1);
    localparam logic [FW-1:0]  FA_TOP  = FW'(FA_DEB - 1);
    localparam logic [HW-1:0]  HOLD_LD = HW'(FA_HOLD);
    localparam logic [SCW-1:0] STALE_N = SCW'(STALE_CYCLES);
    localparam logic [SCW-1:0] STALE_P = SCW'(STALE_CYCLES - 1);

    // Contact lanes: bit 0 front door, 1 rear door, 2 window, 3 fire alarm.
    logic [3:0]    sync1_r;
    logic [3:0]    sync2_r;
    logic [2:0]    door_r;
    logic [DW-1:0] door_cnt_r [3];

    logic          sfa_r;
    logic [FW-1:0] fa_cnt_r;
    logic [HW-1:0] fa_hold_r;

    logic [8:0]     acc_r;
    logic [1:0]     cnt_r;
    logic [6:0]     st_r;
    logic           err_r;
    logic [SCW-1:0] stale_cnt_r;
    logic           stale_r;

    logic       accept_s;
    logic       reject_s;
    logic [8:0] sum_s;

    // Classify the incoming sample and form the running sum including it.
    always_comb begin
        accept_s = 1'b0;
        reject_s = 1'b0;
        sum_s    = acc_r + {2'b00, temp_in};
        if (temp_valid) begin
            if (temp_in <= MAX_T) begin
                accept_s = 1'b1;
            end else begin
                reject_s = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
            reject_s = 1'b0;
        end
    end

    // Two-flop synchroniser for the asynchronous contacts.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= {raw_fa, raw_w, raw_rd, raw_fd};
            sync2_r <= sync1_r;
        end
    end

    // Door/window debounce: an independent stability counter per lane.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            door_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                door_cnt_r[i] <= DW'(0);
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == door_r[i]) begin
                    door_cnt_r[i] <= DW'(0);
                end else if (door_cnt_r[i] == DEB_TOP) begin
                    door_r[i]     <= sync2_r[i];
                    door_cnt_r[i] <= DW'(0);
                end else begin
                    door_cnt_r[i] <= door_cnt_r[i] + DW'(1);
                end
            end
        end
    end

    // Fire alarm: debounce, then a minimum hold once raised. The hold is
    // loaded only on the rising decision, so re-asserting the contact
    // during the hold never extends it.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            sfa_r     <= 1'b0;
            fa_cnt_r  <= FW'(0);
            fa_hold_r <= HW'(0);
        end else if (fa_hold_r != HW'(0)) begin
            fa_hold_r <= fa_hold_r - HW'(1);
            fa_cnt_r  <= FW'(0);
        end else if (sync2_r[3] == sfa_r) begin
            fa_cnt_r <= FW'(0);
        end else if (fa_cnt_r == FA_TOP) begin
            sfa_r    <= sync2_r[3];
            fa_cnt_r <= FW'(0);
            if (sync2_r[3]) begin
                fa_hold_r <= HOLD_LD;
            end else begin
                fa_hold_r <= HW'(0);
            end
        end else begin
            fa_cnt_r <= fa_cnt_r + FW'(1);
        end
    end

    // Block-of-four temperature average and rejected-sample pulse.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            acc_r <= 9'd0;
            cnt_r <= 2'd0;
            st_r  <= RST_T;
            err_r <= 1'b0;
        end else begin
            err_r <= reject_s;
            if (accept_s) begin
                if (cnt_r == 2'd3) begin
                    // Four samples of at most MAX_TEMP fit in 9 bits.
                    st_r  <= sum_s[8:2];
                    acc_r <= 9'd0;
                    cnt_r <= 2'd0;
                end else begin
                    acc_r <= sum_s;
                    cnt_r <= cnt_r + 2'd1;
                end
            end else begin
                acc_r <= acc_r;
                cnt_r <= cnt_r;
            end
        end
    end

    // Staleness: saturating age since the last accepted sample.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            stale_cnt_r <= SCW'(0);
            stale_r     <= 1'b0;
        end else if (accept_s) begin
            stale_cnt_r <= SCW'(0);
            stale_r     <= 1'b0;
        end else if (stale_cnt_r == STALE_P) begin
            stale_cnt_r <= STALE_N;
            stale_r     <= 1'b1;
        end else if (stale_cnt_r != STALE_N) begin
            stale_cnt_r <= stale_cnt_r + SCW'(1);
        end else begin
            stale_cnt_r <= stale_cnt_r;
        end
    end

    assign SFD        = door_r[0];
    assign SRD        = door_r[1];
    assign SW         = door_r[2];
    assign SFA        = sfa_r;
    assign ST         = st_r;
    assign temp_stale = stale_r;
    assign temp_err   = err_r;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Testbench for sensor_conditioner: directed checks with fixed expected
// constants, a table of temperature vectors, and a randomized run compared
// every cycle against a window-based reference model.
module tb_sensor_conditioner;

    localparam int DEB      = 8;
    localparam int FA_DEB   = 2;
    localparam int FA_HOLD  = 16;
    localparam int MAX_TEMP = 120;
    localparam int STALE    = 1024;
    localparam int RST_TEMP = 60;

    logic       Clk;
    logic       Rst;
    logic       raw_fd, raw_rd, raw_w, raw_fa;
    logic [6:0] temp_in;
    logic       temp_valid;
    logic       SFD, SRD, SW, SFA;
    logic [6:0] ST;
    logic       temp_stale, temp_err;

    int vectors;
    int miscompares;

    sensor_conditioner #(
        .DEB_CYCLES(DEB), .FA_DEB(FA_DEB), .FA_HOLD(FA_HOLD),
        .MAX_TEMP(MAX_TEMP), .STALE_CYCLES(STALE), .RST_TEMP(RST_TEMP)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .raw_fd(raw_fd), .raw_rd(raw_rd), .raw_w(raw_w), .raw_fa(raw_fa),
        .temp_in(temp_in), .temp_valid(temp_valid),
        .SFD(SFD), .SRD(SRD), .SW(SW), .SFA(SFA), .ST(ST),
        .temp_stale(temp_stale), .temp_err(temp_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    // Contacts: a flip happens when the last N synchronised samples (since
    // reset, or since the fire-alarm hold ended) all disagree with the output.
    longint     n;
    longint     hold_until;
    longint     last_acc;
    bit [3:0]   d1, d2;
    bit [31:0]  hist [4];
    int         hlen [4];
    bit [3:0]   m_out;
    int         tq [$];
    bit [6:0]   m_st;
    bit         m_stale;
    bit         m_err;

    function automatic bit all_eq(input bit [31:0] h, input int d, input bit v);
        bit [31:0] m;
        m = (32'd1 << d) - 32'd1;
        return (h & m) == (v ? m : 32'd0);
    endfunction

    task automatic m_step();
        bit [3:0] raw;
        bit       s;
        int       sum;
        n++;
        if (!Rst) begin
            d1 = 4'b0; d2 = 4'b0; m_out = 4'b0;
            for (int c = 0; c < 4; c++) begin hist[c] = 32'd0; hlen[c] = 0; end
            hold_until = n; last_acc = n;
            tq.delete();
            m_st = 7'(RST_TEMP); m_stale = 1'b0; m_err = 1'b0;
            return;
        end
        raw = {raw_fa, raw_w, raw_rd, raw_fd};
        for (int c = 0; c < 4; c++) begin
            s = d2[c]; d2[c] = d1[c]; d1[c] = raw[c];
            if (c < 3) begin
                hist[c] = {hist[c][30:0], s}; hlen[c]++;
                if (hlen[c] >= DEB && all_eq(hist[c], DEB, ~m_out[c])) m_out[c] = ~m_out[c];
            end else if (n <= hold_until) begin
                hlen[c] = 0;
            end else begin
                hist[c] = {hist[c][30:0], s}; hlen[c]++;
                if (hlen[c] >= FA_DEB && all_eq(hist[c], FA_DEB, ~m_out[c])) begin
                    m_out[c] = ~m_out[c];
                    if (m_out[c]) hold_until = n + FA_HOLD;
                end
            end
        end
        m_err = temp_valid && (int'(temp_in) > MAX_TEMP);
        if (temp_valid && (int'(temp_in) <= MAX_TEMP)) begin
            tq.push_back(int'(temp_in));
            last_acc = n;
            if (tq.size() == 4) begin
                sum = 0;
                foreach (tq[i]) sum += tq[i];
                m_st = 7'(sum / 4);
                tq.delete();
            end
        end
        m_stale = (n - last_acc) >= STALE;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: model advances at the edge, outputs sampled on the falling edge.
    task automatic step();
        @(posedge Clk);
        m_step();
        @(negedge Clk);
        check("model", 32'({SFD, SRD, SW, SFA, ST, temp_stale, temp_err}),
              32'({m_out[0], m_out[1], m_out[2], m_out[3], m_st, m_stale, m_err}));
    endtask

    typedef struct {
        bit       valid;
        bit [6:0] temp;
        bit [6:0] exp_st;
        bit       exp_err;
    } tvec_t;

    tvec_t tv [16];

    initial begin
        vectors = 0; miscompares = 0; n = 0;
        hold_until = 0; last_acc = 0; m_out = 4'b0; d1 = 4'b0; d2 = 4'b0;
        m_st = 7'(RST_TEMP); m_stale = 1'b0; m_err = 1'b0;
        for (int c = 0; c < 4; c++) begin hist[c] = 32'd0; hlen[c] = 0; end

        tv[0]  = '{1'b1, 7'd70,  7'd60,  1'b0};
        tv[1]  = '{1'b1, 7'd71,  7'd60,  1'b0};
        tv[2]  = '{1'b1, 7'd72,  7'd60,  1'b0};
        tv[3]  = '{1'b1, 7'd74,  7'd71,  1'b0};
        tv[4]  = '{1'b0, 7'd0,   7'd71,  1'b0};
        tv[5]  = '{1'b1, 7'd121, 7'd71,  1'b1};
        tv[6]  = '{1'b0, 7'd0,   7'd71,  1'b0};
        tv[7]  = '{1'b1, 7'd100, 7'd71,  1'b0};
        tv[8]  = '{1'b1, 7'd100, 7'd71,  1'b0};
        tv[9]  = '{1'b1, 7'd127, 7'd71,  1'b1};
        tv[10] = '{1'b1, 7'd100, 7'd71,  1'b0};
        tv[11] = '{1'b1, 7'd104, 7'd101, 1'b0};
        tv[12] = '{1'b1, 7'd120, 7'd101, 1'b0};
        tv[13] = '{1'b1, 7'd120, 7'd101, 1'b0};
        tv[14] = '{1'b1, 7'd120, 7'd101, 1'b0};
        tv[15] = '{1'b1, 7'd0,   7'd90,  1'b0};

        Rst = 1'b0; raw_fd = 1'b0; raw_rd = 1'b0; raw_w = 1'b0; raw_fa = 1'b0;
        temp_in = 7'd0; temp_valid = 1'b0;

        // Reset for 3 clocks, then release.
        for (int k = 0; k < 3; k++) step();
        Rst = 1'b1;
        step();
        check("rst_doors", 32'({SFD, SRD, SW, SFA}), 32'd0);
        check("rst_st", 32'(ST), 32'd60);
        check("rst_stale_err", 32'({temp_stale, temp_err}), 32'd0);

        // Front door latency, DEB+2 clocks after the raw change.
        raw_fd = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k >= 9) check("sfd_latency", 32'(SFD), (k >= 10) ? 32'd1 : 32'd0);
        end

        // Window glitch of 7 cycles never reaches SW.
        raw_w = 1'b1;
        for (int k = 0; k < 7; k++) step();
        raw_w = 1'b0;
        for (int k = 0; k < 15; k++) step();
        check("sw_glitch", 32'(SW), 32'd0);

        // Fire alarm: 3-cycle pulse, rise after 4 clocks, hold, fall 2 after expiry.
        raw_fa = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            if (k == 4) raw_fa = 1'b0;
            step();
            check("sfa_shape", 32'(SFA), (k >= 4 && k <= 21) ? 32'd1 : 32'd0);
        end

        // Temperature table.
        for (int i = 0; i < 16; i++) begin
            temp_valid = tv[i].valid;
            temp_in    = tv[i].temp;
            step();
            check("tbl_st", 32'(ST), 32'(tv[i].exp_st));
            check("tbl_err", 32'(temp_err), 32'(tv[i].exp_err));
        end
        temp_valid = 1'b0; temp_in = 7'd0;

        // Staleness after STALE clocks with no accepted sample.
        for (int k = 1; k <= STALE; k++) begin
            if (k == 10) begin temp_valid = 1'b1; temp_in = 7'd125; end
            if (k == 11) begin temp_valid = 1'b0; temp_in = 7'd0; end
            step();
            if (k == STALE - 1) check("stale_early", 32'(temp_stale), 32'd0);
            if (k == STALE) begin
                check("stale_set", 32'(temp_stale), 32'd1);
                check("stale_st_held", 32'(ST), 32'd90);
            end
        end
        for (int k = 1; k <= 4; k++) begin
            temp_valid = 1'b1; temp_in = 7'd50;
            step();
            if (k == 1) check("stale_clear", 32'(temp_stale), 32'd0);
            check("stale_st_after", 32'(ST), (k == 4) ? 32'd50 : 32'd90);
        end
        temp_valid = 1'b0;

        // Reset mid-operation: partial average and pending debounce discarded.
        raw_rd = 1'b1;
        temp_valid = 1'b1; temp_in = 7'd40;
        step(); step();
        temp_valid = 1'b0;
        step(); step();
        Rst = 1'b0; raw_rd = 1'b0; raw_fd = 1'b0;
        step(); step();
        Rst = 1'b1;
        step();
        check("midrst_st", 32'(ST), 32'd60);
        check("midrst_srd", 32'(SRD), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            temp_valid = 1'b1; temp_in = 7'd40;
            step();
            check("midrst_avg", 32'(ST), (k == 4) ? 32'd40 : 32'd60);
        end
        check("midrst_srd_end", 32'(SRD), 32'd0);
        temp_valid = 1'b0;

        // Randomized run against the model.
        for (int k = 0; k < 4000; k++) begin
            Rst = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 11) == 0) raw_fd = ~raw_fd;
            if ($urandom_range(0, 11) == 0) raw_rd = ~raw_rd;
            if ($urandom_range(0, 11) == 0) raw_w  = ~raw_w;
            if ($urandom_range(0, 9)  == 0) raw_fa = ~raw_fa;
            temp_valid = ($urandom_range(0, 2) == 0);
            temp_in    = 7'($urandom_range(0, 127));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
